// File: rtl/float_divide_iter.sv
// Iterative IEEE-style floating-point divider: one restoring quotient bit per cycle,
// truncated result with trailing/sticky bits handed back for external rounding.
module float_divide_iter #(
  parameter int EXP           = 8,
  parameter int FRAC          = 23,
  parameter int TRAILING_BITS = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [EXP+FRAC:0]        inA,
  input  logic [EXP+FRAC:0]        inB,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [EXP+FRAC:0]        out,
  output logic [TRAILING_BITS-1:0] trailingBits,
  output logic                     stickyBit,
  output logic                     isNan
);

  localparam int W   = 1 + EXP + FRAC;
  localparam int Q   = FRAC + TRAILING_BITS + 2;
  localparam int EW  = EXP + 2;
  localparam int VW  = FRAC + TRAILING_BITS + 1;
  localparam int RW  = FRAC + 3;
  localparam int LZW = $clog2(FRAC + 2);
  localparam int CW  = $clog2(Q);
  localparam int TB  = TRAILING_BITS;

  localparam logic signed [EW-1:0] BIAS = EW'(2 ** (EXP - 1) - 1);
  localparam logic signed [EW-1:0] MAXE = EW'(2 ** EXP - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] ZERO = EW'(0);
  localparam logic signed [EW-1:0] MAXS = EW'(VW);

  typedef enum logic [2:0] {IDLE, PREP, DIV, PACK, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t   state;
  special_t special;
  logic [CW-1:0] cnt;

  logic [W-1:0]           opA, opB;
  logic [RW-1:0]          rem;
  logic [FRAC:0]          div;
  logic [Q-1:0]           quo;
  logic signed [EW-1:0]   expQ;
  logic                   signQ;

  function automatic logic [LZW-1:0] lzc(input logic [FRAC:0] m);
    logic [LZW-1:0] n;
    logic found;
    n = '0;
    found = 1'b0;
    for (int i = FRAC; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + 1'b1;
      end
    end
    return n;
  endfunction

  // Denormal inputs sit at exponent 1 before normalisation, so each shift costs one.
  function automatic logic signed [EW-1:0] effExp(input logic [EXP-1:0] e, input logic [LZW-1:0] lz);
    if (e == '0) return ONE - $signed(EW'(lz));
    return $signed({2'b00, e});
  endfunction

  // Right shift for gradual underflow: {kept bits, OR of everything shifted out}.
  function automatic logic [VW-1:0] denormShift(input logic [VW-1:0] v, input logic [EW-1:0] sh);
    logic [2*VW-2:0] wide;
    wide = (2*VW-1)'({v, {VW{1'b0}}} >> sh);
    return {wide[2*VW-2:VW], |wide[VW-1:0]};
  endfunction

  // ---- operand classification / normalisation (PREP inputs)
  logic [EXP-1:0]  expA, expB;
  logic [FRAC-1:0] fracA, fracB;
  logic [FRAC:0]   mA, mB, nA, nB;
  logic [LZW-1:0]  lzA, lzB;
  logic nanA, nanB, infA, infB, zA, zB;
  special_t prepSpecial;

  always_comb begin
    expA  = opA[W-2:FRAC];
    expB  = opB[W-2:FRAC];
    fracA = opA[FRAC-1:0];
    fracB = opB[FRAC-1:0];
    mA    = {|expA, fracA};
    mB    = {|expB, fracB};
    lzA   = lzc(mA);
    lzB   = lzc(mB);
    nA    = mA << lzA;
    nB    = mB << lzB;
    nanA  = (&expA) & (|fracA);
    nanB  = (&expB) & (|fracB);
    infA  = (&expA) & ~(|fracA);
    infB  = (&expB) & ~(|fracB);
    zA    = ~(|expA) & ~(|fracA);
    zB    = ~(|expB) & ~(|fracB);
    prepSpecial = SP_NONE;
    if (nanA || nanB || (zA && zB) || (infA && infB)) prepSpecial = SP_NAN;
    else if (infA || zB)                              prepSpecial = SP_INF;
    else if (zA || infB)                              prepSpecial = SP_ZERO;
  end

  // ---- restoring division step
  logic          ge;
  logic [RW-1:0] remSub;

  always_comb begin
    ge     = rem >= RW'(div);
    remSub = ge ? rem - RW'(div) : rem;
  end

  always_ff @(posedge clock) begin
    case (state)
      IDLE: if (inValid) begin
        opA <= inA;
        opB <= inB;
      end
      PREP: begin
        rem     <= RW'(nA);
        div     <= nB;
        expQ    <= effExp(expA, lzA) - effExp(expB, lzB) + BIAS;
        special <= prepSpecial;
        signQ   <= opA[W-1] ^ opB[W-1];
      end
      DIV: begin
        rem <= {remSub[RW-2:0], 1'b0};
        quo <= {quo[Q-2:0], ge};
      end
      default: ;
    endcase
  end

  // ---- normalise, pack, overflow / underflow handling (PACK outputs)
  logic [Q-1:0]          qn;
  logic signed [EW-1:0]  eN, shS;
  logic [FRAC-1:0]       fr;
  logic [TB-1:0]         tr;
  logic                  st, dLost;
  logic [VW-2:0]         dKeep;
  logic [W-1:0]          pOut;
  logic [TB-1:0]         pTrail;
  logic                  pSticky, pNan;

  always_comb begin
    qn  = quo[Q-1] ? quo : {quo[Q-2:0], 1'b0};
    eN  = quo[Q-1] ? expQ : expQ - ONE;
    fr  = qn[Q-2 -: FRAC];
    tr  = qn[Q-2-FRAC -: TB];
    st  = qn[0] | (|rem);
    shS = ONE - eN;
    {dKeep, dLost} = denormShift({1'b1, fr, tr}, shS);
    pOut    = {signQ, eN[EXP-1:0], fr};
    pTrail  = tr;
    pSticky = st;
    pNan    = 1'b0;
    if (eN >= MAXE) begin
      pOut    = {signQ, {EXP{1'b1}}, {FRAC{1'b0}}};
      pTrail  = '0;
      pSticky = 1'b0;
    end else if (eN <= ZERO) begin
      if (shS > MAXS) begin
        pOut    = {signQ, {(EXP+FRAC){1'b0}}};
        pTrail  = '0;
        pSticky = 1'b1;
      end else begin
        pOut    = {signQ, {EXP{1'b0}}, dKeep[VW-2:TB]};
        pTrail  = dKeep[TB-1:0];
        pSticky = st | dLost;
      end
    end
    case (special)
      SP_NAN: begin
        pOut    = {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};
        pNan    = 1'b1;
        pTrail  = '0;
        pSticky = 1'b0;
      end
      SP_INF: begin
        pOut    = {signQ, {EXP{1'b1}}, {FRAC{1'b0}}};
        pTrail  = '0;
        pSticky = 1'b0;
      end
      SP_ZERO: begin
        pOut    = {signQ, {(EXP+FRAC){1'b0}}};
        pTrail  = '0;
        pSticky = 1'b0;
      end
      default: ;
    endcase
  end

  // ---- control FSM and registered result
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      out          <= '0;
      trailingBits <= '0;
      stickyBit    <= 1'b0;
      isNan        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (inValid) state <= PREP;
        PREP: begin
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(Q - 1)) state <= PACK;
        end
        PACK: begin
          out          <= pOut;
          trailingBits <= pTrail;
          stickyBit    <= pSticky;
          isNan        <= pNan;
          state        <= DONE;
        end
        DONE: if (outReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign inReady  = (state == IDLE);
  assign outValid = (state == DONE);

endmodule

// File: tb/tb_float_divide_iter.sv
// Directed bench for float_divide_iter at single-precision parameters.
module tb_float_divide_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] inA, inB;
  logic        outValid;
  logic        outReady;
  logic [31:0] out;
  logic [1:0]  trailingBits;
  logic        stickyBit;
  logic        isNan;

  int compared   = 0;
  int mismatched = 0;

  float_divide_iter #(.EXP(8), .FRAC(23), .TRAILING_BITS(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .inValid      (inValid),
    .inReady      (inReady),
    .inA          (inA),
    .inB          (inB),
    .outValid     (outValid),
    .outReady     (outReady),
    .out          (out),
    .trailingBits (trailingBits),
    .stickyBit    (stickyBit),
    .isNan        (isNan)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expOut, input logic [1:0] expTr,
                       input logic expSt, input logic expNan,
                       input int holdCycles, input bit noisy);
    int n;
    @(posedge clock);
    #1;
    check({tag, " inReady idle"}, inReady, 1);
    inValid = 1'b1;
    inA = a;
    inB = b;
    @(posedge clock);
    #1;
    if (noisy) begin
      inA = 32'h3F800000;
      inB = 32'h3F800000;
    end else begin
      inValid = 1'b0;
    end
    check({tag, " inReady busy"}, inReady, 0);
    n = 0;
    while (outValid !== 1'b1 && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    inValid = 1'b0;
    check({tag, " latency"}, n, 29);
    check({tag, " out"}, out, expOut);
    check({tag, " trailing"}, trailingBits, expTr);
    check({tag, " sticky"}, stickyBit, expSt);
    check({tag, " isNan"}, isNan, expNan);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clock);
      #1;
      check({tag, " hold outValid"}, outValid, 1);
      check({tag, " hold inReady"}, inReady, 0);
      check({tag, " hold out"}, out, expOut);
      check({tag, " hold trailing"}, trailingBits, expTr);
      check({tag, " hold sticky"}, stickyBit, expSt);
    end
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    check({tag, " release outValid"}, outValid, 0);
    check({tag, " release inReady"}, inReady, 1);
  endtask

  initial begin
    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    inA      = '0;
    inB      = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset outValid", outValid, 0);
    check("reset out", out, 0);
    check("reset trailing", trailingBits, 0);
    check("reset sticky", stickyBit, 0);
    check("reset isNan", isNan, 0);
    check("reset inReady", inReady, 1);

    runOp("6/2 backpressure", 32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 1'b0, 1'b0, 5, 1'b0);
    runOp("1/3",              32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 2'b10, 1'b1, 1'b0, 0, 1'b1);
    runOp("1/0",              32'h3F800000, 32'h00000000, 32'h7F800000, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    runOp("0/0",              32'h00000000, 32'h00000000, 32'h7FC00000, 2'b00, 1'b0, 1'b1, 0, 1'b0);
    runOp("max/0.5",          32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    runOp("minnorm/2",        32'h00800000, 32'h40000000, 32'h00400000, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    runOp("denorm/0.5",       32'h00400000, 32'h3F000000, 32'h00800000, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    runOp("denorm trail",     32'h00800001, 32'h40000000, 32'h00400000, 2'b10, 1'b0, 1'b0, 0, 1'b0);
    runOp("deep underflow",   32'h00000001, 32'h7F000000, 32'h00000000, 2'b00, 1'b1, 1'b0, 0, 1'b0);
    runOp("-1/2",             32'hBF800000, 32'h40000000, 32'hBF000000, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    runOp("nan in",           32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2'b00, 1'b0, 1'b1, 0, 1'b0);
    runOp("-inf/2",           32'hFF800000, 32'h40000000, 32'hFF800000, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    runOp("1/inf",            32'h3F800000, 32'h7F800000, 32'h00000000, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    runOp("-0/1",             32'h80000000, 32'h3F800000, 32'h80000000, 2'b00, 1'b0, 1'b0, 0, 1'b0);

    // Abort an operation part-way through the divide loop.
    @(posedge clock);
    #1;
    inValid = 1'b1;
    inA = 32'h3F800000;
    inB = 32'h40400000;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    check("mid-div inReady", inReady, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort outValid", outValid, 0);
    check("abort inReady", inReady, 1);
    check("abort out", out, 0);
    check("abort isNan", isNan, 0);

    runOp("6/2 after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 1'b0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
